sdm_interp_upsampler: RTL

- Upstream feeder for the MASH sigma-delta modulator.
- Accepts baseband samples at 1/OSR of the clk rate through a valid/ready handshake.
- Linearly interpolates between consecutive samples and drives one sample per clk into the modulator's 16-bit input x1.
- Tracks input underrun with a sticky flag, so software or the testbench can detect starved sample sources.

---
 rtl/sdm_interp_upsampler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sdm_interp_upsampler.sv
// Linear-interpolating upsampler feeding the MASH sigma-delta modulator input.
// Takes one sample per 2**OSR_LOG2 clocks via valid/ready and emits one registered sample per clock.
module sdm_interp_upsampler #(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr_underrun,
  output logic [WIDTH-1:0] x1_out,
  output logic             x1_valid,
  output logic             underrun
);

  localparam int PW = WIDTH + 1 + OSR_LOG2;

  typedef enum logic [1:0] {EMPTY, RUN, STALL} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    p_q, p_d;
  logic [WIDTH-1:0]    c_q, c_d;
  logic [WIDTH-1:0]    buf_q, buf_d;
  logic                buf_v_q, buf_v_d;
  logic [OSR_LOG2-1:0] k_q, k_d;
  logic [WIDTH-1:0]    x1_q, x1_d;
  logic                x1_v_q, x1_v_d;
  logic                underrun_q, underrun_d;
  logic                underrun_set;

  logic signed [WIDTH:0]  diff;
  logic signed [PW-1:0]   diff_ext;
  logic signed [PW-1:0]   k_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   step;
  logic [WIDTH-1:0]       interp;

  // The exact result lies between P and C, so wrapping WIDTH-bit addition is exact.
  assign diff     = {c_q[WIDTH-1], c_q} - {p_q[WIDTH-1], p_q};
  assign diff_ext = {{OSR_LOG2{diff[WIDTH]}}, diff};
  assign k_ext    = {{(WIDTH + 1){1'b0}}, k_q};
  assign prod     = diff_ext * k_ext;
  assign step     = prod >>> OSR_LOG2;
  assign interp   = p_q + step[WIDTH-1:0];

  assign in_ready = !buf_v_q;
  assign x1_out   = x1_q;
  assign x1_valid = x1_v_q;
  assign underrun = underrun_q;

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    c_d          = c_q;
    buf_d        = buf_q;
    buf_v_d      = buf_v_q;
    k_d          = k_q;
    x1_d         = x1_q;
    x1_v_d       = x1_v_q;
    underrun_set = 1'b0;

    unique case (state_q)
      EMPTY: begin
        x1_d   = '0;
        x1_v_d = 1'b0;
        if (buf_v_q) begin
          p_d     = buf_q;
          c_d     = buf_q;
          buf_v_d = 1'b0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x1_d   = interp;
        x1_v_d = 1'b1;
        if (k_q != '1) begin
          k_d = k_q + OSR_LOG2'(1);
        end else begin
          p_d = c_q;
          k_d = '0;
          if (buf_v_q) begin
            c_d     = buf_q;
            buf_v_d = 1'b0;
          end else begin
            underrun_set = 1'b1;
            state_d      = STALL;
          end
        end
      end
      STALL: begin
        x1_d   = c_q;
        x1_v_d = 1'b1;
        if (buf_v_q) begin
          c_d     = buf_q;
          buf_v_d = 1'b0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A consume only happens with buf_v_q=1, when no accept is possible.
    if (in_valid && !buf_v_q) begin
      buf_d   = in_data;
      buf_v_d = 1'b1;
    end

    if (underrun_set)      underrun_d = 1'b1;
    else if (clr_underrun) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      p_q        <= '0;
      c_q        <= '0;
      buf_q      <= '0;
      buf_v_q    <= 1'b0;
      k_q        <= '0;
      x1_q       <= '0;
      x1_v_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      c_q        <= c_d;
      buf_q      <= buf_d;
      buf_v_q    <= buf_v_d;
      k_q        <= k_d;
      x1_q       <= x1_d;
      x1_v_q     <= x1_v_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
